// File: rtl/nms_stage_if.sv
// AXI-stream style handshake bundle shared by the NMS stage input and output.
interface nms_stage_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/nms_stage.sv
// Canny non-maximum suppression: keeps a pixel only if its magnitude is a local
// maximum along its quantised gradient direction, else emits 0.
module nms_stage #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
) (
    input  logic         clk,
    input  logic         resetn,
    nms_stage_if.slave   s_axis,
    nms_stage_if.master  m_axis
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT + 2);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    typedef logic [14:0] px_t;

    logic [1:0]    state;
    logic [CW-1:0] in_c;
    logic [RW-1:0] in_r;

    px_t lb0 [IMG_WIDTH];
    px_t lb1 [IMG_WIDTH];
    // Two registered columns of the 3x3 window; the third (right) column is the live one.
    px_t win [3][2];
    px_t col_new [3];
    px_t in_px;
    px_t ctr;

    logic          step, emit, wrap_c;
    logic [CW-1:0] oc;
    logic [RW-1:0] orow;
    logic          top_ok, bot_ok, lft_ok, rgt_ok;
    logic [11:0]   mag, na, nb;
    logic [7:0]    out_px;
    logic          unused_tlast;

    assign unused_tlast = s_axis.tlast;

    assign s_axis.tready = (state != FLUSH) && (!m_axis.tvalid || m_axis.tready);
    assign step   = (state == FLUSH) ? (!m_axis.tvalid || m_axis.tready)
                                     : (s_axis.tvalid && s_axis.tready);
    assign emit   = step && (state != FILL);
    assign wrap_c = (in_c == CW'(IMG_WIDTH - 1));
    assign in_px  = (state == FLUSH) ? '0 : s_axis.tdata;

    assign col_new[0] = lb1[in_c];
    assign col_new[1] = lb0[in_c];
    assign col_new[2] = in_px;

    // The step at input position (i,j) centres the window on (i-1,j-1), wrapping to
    // column W-1 of row i-2 when j==0; the wrapped right column is always masked.
    assign oc   = (in_c == '0) ? CW'(IMG_WIDTH - 1) : in_c - CW'(1);
    assign orow = (in_c == '0) ? in_r - RW'(2) : in_r - RW'(1);

    assign top_ok = (orow != '0);
    assign bot_ok = (orow != RW'(IMG_HEIGHT - 1));
    assign lft_ok = (oc != '0);
    assign rgt_ok = (oc != CW'(IMG_WIDTH - 1));

    assign ctr = win[1][1];
    assign mag = ctr[11:0];

    function automatic logic [11:0] nmag(input px_t p, input logic ok);
        return ok ? p[11:0] : 12'd0;
    endfunction

    always_comb begin
        na = '0;
        nb = '0;
        case (ctr[14:12])
            3'd0, 3'd4: begin
                na = nmag(win[1][0], lft_ok);
                nb = nmag(col_new[1], rgt_ok);
            end
            3'd2, 3'd6: begin
                na = nmag(win[0][1], top_ok);
                nb = nmag(win[2][1], bot_ok);
            end
            3'd1, 3'd5: begin
                na = nmag(win[0][0], top_ok && lft_ok);
                nb = nmag(col_new[2], bot_ok && rgt_ok);
            end
            default: begin
                na = nmag(col_new[0], top_ok && rgt_ok);
                nb = nmag(win[2][0], bot_ok && lft_ok);
            end
        endcase
    end

    always_comb begin
        out_px = '0;
        if (mag >= na && mag >= nb)
            out_px = (|mag[11:8]) ? 8'hFF : mag[7:0];
    end

    // Row buffers are never cleared: out-of-frame taps are masked instead.
    always_ff @(posedge clk) begin
        if (step) begin
            lb0[in_c] <= in_px;
            lb1[in_c] <= lb0[in_c];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= FILL;
            in_c          <= '0;
            in_r          <= '0;
            win           <= '{default: '0};
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
        end else begin
            if (emit) begin
                m_axis.tdata  <= out_px;
                m_axis.tlast  <= (orow == RW'(IMG_HEIGHT - 1)) && (oc == CW'(IMG_WIDTH - 1));
                m_axis.tvalid <= 1'b1;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end

            if (step) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= col_new[i];
                end
                if (state == FLUSH && in_r == RW'(IMG_HEIGHT + 1)) begin
                    state <= FILL;
                    in_c  <= '0;
                    in_r  <= '0;
                end else begin
                    in_c <= wrap_c ? '0 : in_c + CW'(1);
                    if (wrap_c)
                        in_r <= in_r + RW'(1);
                    if (state == FILL && in_r == RW'(1))
                        state <= RUN;
                    if (state == RUN && in_r == RW'(IMG_HEIGHT - 1) && wrap_c)
                        state <= FLUSH;
                end
            end
        end
    end
endmodule

// File: doc/nms_stage.md
Name: nms_stage

Overview:
- Non-maximum suppression stage. Consumes the 15-bit {direction[2:0], magnitude[11:0]} gradient stream produced by the Sobel stage. Emits an 8-bit thinned-edge magnitude stream of the same frame size.
- Each pixel is kept only if its magnitude is not smaller than either neighbour along its quantised gradient direction. Otherwise it is output as 0.
- Sits between the Sobel stage and the hysteresis/threshold stage in the Canny pipeline.

Parameters:
- IMG_WIDTH, 128, pixels per row (≥3).
- IMG_HEIGHT, 128, rows per frame (≥3).

Ports:
- clk, input, 1, clock.
- resetn, input, 1, asynchronous active-low reset.
- s_axis_tdata, input, 15, {dir[14:12], mag[11:0]}.
- s_axis_tvalid, input, 1, input valid.
- s_axis_tready, output, 1, input ready.
- s_axis_tlast, input, 1, end of frame from upstream; ignored, framing is by internal count.
- m_axis_tdata, output, 8, suppressed magnitude.
- m_axis_tvalid, output, 1, output valid.
- m_axis_tready, input, 1, downstream ready.
- m_axis_tlast, output, 1, high on output pixel W*H-1.

Behaviour:
- Reset (async, resetn=0): m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0; all counters 0; FSM in FILL.
  - Line-buffer contents need not be cleared; out-of-frame neighbours are masked, not read.
- Input transfer: s_axis_tvalid && s_axis_tready.
- s_axis_tready = (state != FLUSH) && (!m_axis_tvalid || m_axis_tready).
- Storage: two row buffers of (IMG_WIDTH × 15 bits) plus a 3×3 window of {dir,mag}.
- Pixels are indexed in raster order, k = r*W + c.
- Trigger rule: output pixel (r,c) is computed on the "step" whose index is k = (r+1)*W + c + 1.
  - Steps with k ≤ W*H-1 are input transfers.
  - Steps with k ≥ W*H are virtual flush steps with zero data.
- Latency: output (r,c) is registered on m_axis the cycle after its step.
- FSM:
  - FILL: accept pixels 0..W; no output. After the transfer of pixel W → RUN.
  - RUN: each transfer is a step and emits one output. After the transfer of pixel W*H-1 → FLUSH.
  - FLUSH: s_axis_tready=0. One virtual step per cycle when (!m_axis_tvalid || m_axis_tready); W+1 steps in total. After the last step → FILL, all counters cleared.
  - The next frame may start the cycle after FLUSH exits.
- Output register:
  - On a step, load tdata/tlast and set tvalid=1.
  - Else, if m_axis_tready, clear tvalid=0.
  - tdata/tlast are held stable while tvalid && !tready.
- Neighbour selection (row r-1 is up, c+1 is right):
  - dir 0/4: (r,c-1), (r,c+1).
  - dir 2/6: (r-1,c), (r+1,c).
  - dir 1/5: (r-1,c-1), (r+1,c+1).
  - dir 3/7: (r-1,c+1), (r+1,c-1).
- Any neighbour outside 0..H-1 / 0..W-1 is treated as magnitude 0. Column masking must not wrap to the adjacent row.
- Decision: keep if mag ≥ nA and mag ≥ nB, else output 0.
- Kept value: mag>255 → 255, else mag[7:0]. Comparisons use the full unsigned 12-bit mag.
- tlast: asserted with output (H-1,W-1) only; exactly W*H outputs per frame.
- Boundary conditions:
  - Output stalled on the final RUN transfer: FLUSH steps wait for the stall to clear.
  - Input tvalid gaps: no step, and no tvalid bubble is created beyond what the gap itself causes.
  - Reset mid-frame: partial frame discarded; the next accepted pixel is (0,0).

Test Plan:
- W=H=4, all inputs {dir0, mag10}, m_axis_tready=1 → 16 outputs of 10; tlast only on the 16th; no output before pixel 5 is accepted; 5 outputs during FLUSH.
- W=H=4, all {dir0, mag50} except (1,1)={dir0, mag100} → (1,1)=100; (1,0)=0; (1,2)=0; all other 13 outputs =50.
- W=H=4, diagonal (i,i)={dir3, mag200}, others {dir3, mag20} → diagonal =200; (0,2), (2,0), (1,3), (3,1) =0; all others =20.
- Single pixel mag=12'd300 with neighbours 0; and mag=12'd255 vs neighbour 12'd256 → outputs 255 and 0 respectively.
- Repeat the peak case with m_axis_tready random (50%) and s_axis_tvalid random gaps → output sequence identical to the unstalled run; tdata stable while stalled; s_axis_tready=0 whenever m_axis_tvalid && !m_axis_tready.
- Two back-to-back frames (second all mag 7, dir2); then assert resetn=0 mid-third-frame and send a fresh frame → frame 2 outputs all 7 with no frame-1 leakage in row 0; after reset, outputs are all 0 until first output; 16 correct outputs follow.
